// File: rtl/cla_multiword_seq.sv
// -----------------------------------------------------------------------------
// cla_multiword_seq
// Sequential multi-word adder. Two TOTAL = WIDTH*SLICES bit operands are added
// one WIDTH-bit slice per clock through a single carry-lookahead slice. The
// slice carry-out is held in a register and fed into the next slice.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, only sampled while idle
//   a, b   - TOTAL-bit operands, captured on an accepted start
//   c_in   - initial carry, captured on an accepted start
//   sub    - (only with CLA_MULTIWORD_SUB_EN) 1 = compute a - b
//   busy   - high while an operation is running and in its done cycle
//   done   - one-cycle pulse, sum/c_out/ovf valid
//   sum    - registered result
//   c_out  - carry out of the MSB slice (with sub: 1 = no borrow)
//   ovf    - signed overflow (carry into MSB xor carry out of MSB)
//
// Optional feature macro: CLA_MULTIWORD_SUB_EN (adds the sub input).
// -----------------------------------------------------------------------------
module cla_multiword_seq #(
    parameter int WIDTH  = 4,
    parameter int SLICES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WIDTH*SLICES-1:0]   a,
    input  logic [WIDTH*SLICES-1:0]   b,
    input  logic                      c_in,
`ifdef CLA_MULTIWORD_SUB_EN
    input  logic                      sub,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*SLICES-1:0]   sum,
    output logic                      c_out,
    output logic                      ovf
);

    localparam int TOTAL = WIDTH * SLICES;
    localparam int CNT_W = $clog2(SLICES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

    // One CLA slice: returns {carry_out, carry_into_msb, sum}.
    function automatic logic [WIDTH+1:0] cla_slice(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        logic [WIDTH:0]   c;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] s;
        g    = x & y;
        p    = x | y;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            s[i]   = x[i] ^ y[i] ^ c[i];
        end
        return {c[WIDTH], c[WIDTH-1], s};
    endfunction

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic [TOTAL-1:0] a_r;
    logic [TOTAL-1:0] b_r;
    logic [TOTAL-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;
    logic             done_r;
    logic             busy_r;

    logic [TOTAL-1:0] b_load_s;
    logic             carry_load_s;
    logic [WIDTH-1:0] slice_a_s;
    logic [WIDTH-1:0] slice_b_s;
    logic [WIDTH+1:0] slice_res_s;
    logic [WIDTH-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic             slice_cmsb_s;

    // Operand B and initial carry as loaded on an accepted start.
    always_comb begin
        b_load_s     = b;
        carry_load_s = c_in;
`ifdef CLA_MULTIWORD_SUB_EN
        // Two's complement subtract: invert B and force the carry in.
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = c_in;
        end
`endif
    end

    // Current slice operands and the CLA slice result.
    always_comb begin
        slice_a_s    = a_r[cnt_r*WIDTH +: WIDTH];
        slice_b_s    = b_r[cnt_r*WIDTH +: WIDTH];
        slice_res_s  = cla_slice(slice_a_s, slice_b_s, carry_r);
        slice_sum_s  = slice_res_s[WIDTH-1:0];
        slice_cmsb_s = slice_res_s[WIDTH];
        slice_cout_s = slice_res_s[WIDTH+1];
    end

    // Control FSM, operand capture and per-slice result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {TOTAL{1'b0}};
            b_r     <= {TOTAL{1'b0}};
            sum_r   <= {TOTAL{1'b0}};
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b_load_s;
                        carry_r <= carry_load_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_r[cnt_r*WIDTH +: WIDTH] <= slice_sum_s;
                    carry_r                     <= slice_cout_s;
                    if (cnt_r == LAST_SLICE) begin
                        // Counter is cleared here so it never wraps by overflow.
                        c_out_r <= slice_cout_s;
                        ovf_r   <= slice_cmsb_s ^ slice_cout_s;
                        done_r  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign c_out = c_out_r;
    assign ovf   = ovf_r;

endmodule
